// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential word fetches, buffers up to two
// returned instructions with their PCs, and drops in-flight responses after a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [1:0]  outstanding;
  logic [1:0]  stale;
  logic [1:0]  fifo_count;
  logic        head;
  logic [31:0] fifo_instr [2];
  logic [31:0] fifo_pc    [2];

  logic        req_fire;
  logic        rsp_legal;
  logic        rsp_fetch;
  logic        rsp_push;
  logic        pop;
  logic        tail;
  logic [1:0]  inflight_next;
  logic [31:0] rsp_pc;
  logic [31:0] target_pc;
  logic        unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];
  assign target_pc = {redirect_pc[31:2], 2'b00};

  // Credit counts both in-flight requests and buffered entries, so the
  // FIFO can never overflow and responses never need back-pressure.
  assign imem_req_valid = (state == FETCH) &&
                          ((3'(outstanding) + 3'(fifo_count)) < 3'd2);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing in flight is dropped without touching any count.
  assign rsp_legal = imem_rsp_valid &&
                     (((state == FETCH) && (outstanding != 2'd0)) ||
                      ((state == FLUSH) && (stale != 2'd0)));
  assign rsp_fetch = rsp_legal && (state == FETCH);
  assign rsp_push  = rsp_fetch && !redirect_valid;

  // Requests since the last redirect are consecutive words, so the oldest
  // outstanding one sits outstanding*4 bytes behind fetch_pc.
  assign rsp_pc        = fetch_pc - {28'd0, outstanding, 2'b00};
  assign inflight_next = outstanding + 2'(req_fire) - 2'(rsp_fetch);

  assign instr_valid    = (fifo_count != 2'd0);
  assign instr          = fifo_instr[head];
  assign instr_pc       = fifo_pc[head];
  assign instr_pc_plus4 = instr_pc + 32'd4;
  assign pop            = instr_valid && instr_ready && !redirect_valid;
  assign tail           = head ^ fifo_count[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      outstanding <= 2'd0;
      stale       <= 2'd0;
      fifo_count  <= 2'd0;
      head        <= 1'b0;
      // NOTE: the two FIFO slots are reset because the head entry drives
      // instr/instr_pc directly and must read as zero out of reset.
      for (int i = 0; i < 2; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (redirect_valid) fetch_pc <= target_pc;
        end
        FETCH: begin
          if (redirect_valid) begin
            fetch_pc    <= target_pc;
            fifo_count  <= 2'd0;
            outstanding <= 2'd0;
            stale       <= inflight_next;
            state       <= (inflight_next != 2'd0) ? FLUSH : FETCH;
          end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            outstanding <= inflight_next;
            if (rsp_push) begin
              fifo_instr[tail] <= imem_rsp_data;
              fifo_pc[tail]    <= rsp_pc;
            end
            fifo_count <= fifo_count + 2'(rsp_push) - 2'(pop);
            if (pop) head <= ~head;
          end
        end
        FLUSH: begin
          if (redirect_valid) fetch_pc <= target_pc;
          if (rsp_legal) begin
            stale <= stale - 2'd1;
            if (stale == 2'd1) state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected requests and
// instructions, a monitor pops and compares on each handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc, instr_pc_plus4;

  logic        w_req_valid, w_rsp_valid, w_instr_valid;
  logic [31:0] w_req_addr, w_rsp_data, w_instr, w_pc, w_pc4;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(w_instr_valid), .instr_ready(1'b1),
    .instr(w_instr), .instr_pc(w_pc), .instr_pc_plus4(w_pc4)
  );

  typedef struct { logic [31:0] pc; logic [31:0] data; } instr_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  logic [31:0] exp_req[$];
  instr_t      exp_instr[$];
  pend_t       pend[$];
  int          checks = 0, errors = 0, cyc = 0, req_fired = 0;
  bit          mem_hold = 0, stray = 0;

  logic        w_last_fire = 0, w_got = 0;
  logic [31:0] w_last_addr = 0, w_first_pc = 0, w_first_pc4 = 0, w_first_instr = 0;
  logic [31:0] w_addr_log [2];
  int          w_nreq = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] a);
    exp_req.push_back(a);
  endtask

  // Memory returns the bitwise complement of the address as the instruction.
  task automatic push_instr(input logic [31:0] pc);
    instr_t e;
    e.pc = pc;
    e.data = ~pc;
    exp_instr.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue_reqs(input int n);
    int start;
    int budget;
    start = req_fired;
    budget = 0;
    imem_req_ready = 1'b1;
    while (req_fired < start + n && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    imem_req_ready = 1'b0;
    check("issue_count", 32'(req_fired - start), 32'(n));
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_instr.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("drain_left", 32'(exp_instr.size()), 32'd0);
  endtask

  // Main memory model: fixed one-cycle latency unless held.
  initial begin
    pend_t p;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      #1;
      if (!rst) begin
        pend.delete();
        imem_rsp_valid = 1'b0;
      end else if (stray) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        stray = 1'b0;
      end else if (!mem_hold && pend.size() != 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~p.addr;
      end else begin
        imem_rsp_valid = 1'b0;
      end
      #3;
      if (rst && imem_req_valid && imem_req_ready) begin
        p.addr = imem_req_addr;
        p.due  = cyc + 1;
        pend.push_back(p);
      end
    end
  end

  // Wrap-instance memory and logger: records first two requests and first instruction.
  initial begin
    w_rsp_valid = 1'b0;
    w_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        w_rsp_valid = 1'b0;
        w_last_fire = 1'b0;
      end else begin
        w_rsp_valid = w_last_fire;
        w_rsp_data  = ~w_last_addr;
      end
      #3;
      w_last_fire = rst && w_req_valid;
      w_last_addr = w_req_addr;
      if (w_last_fire && w_nreq < 2) begin
        w_addr_log[w_nreq] = w_req_addr;
        w_nreq++;
      end
      if (rst && w_instr_valid && !w_got) begin
        w_got = 1'b1;
        w_first_pc = w_pc;
        w_first_pc4 = w_pc4;
        w_first_instr = w_instr;
      end
    end
  end

  // Monitor: pops expectations on each handshake, checks stall stability.
  initial begin
    logic        held;
    logic        req_wait;
    logic [31:0] h_instr, h_pc, w_addr;
    instr_t      e;
    held = 1'b0;
    req_wait = 1'b0;
    h_instr = '0;
    h_pc = '0;
    w_addr = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        held = 1'b0;
        req_wait = 1'b0;
      end else begin
        if (held && instr_valid) begin
          check("hold_instr", instr, h_instr);
          check("hold_pc", instr_pc, h_pc);
        end
        if (req_wait && imem_req_valid) check("req_addr_stable", imem_req_addr, w_addr);
        if (imem_req_valid && imem_req_ready) begin
          req_fired++;
          if (exp_req.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got %h expected none", imem_req_addr);
          end else begin
            check("req_addr", imem_req_addr, exp_req.pop_front());
          end
        end
        if (instr_valid && instr_ready) begin
          if (exp_instr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_instr: got pc %h expected none", instr_pc);
          end else begin
            e = exp_instr.pop_front();
            check("instr_pc", instr_pc, e.pc);
            check("instr", instr, e.data);
            check("instr_pc_plus4", instr_pc_plus4, e.pc + 32'd4);
          end
        end
        held     = instr_valid && !instr_ready && !redirect_valid;
        h_instr  = instr;
        h_pc     = instr_pc;
        req_wait = imem_req_valid && !imem_req_ready && !redirect_valid;
        w_addr   = imem_req_addr;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;

    // Reset values
    wait_cycles(3);
    #2;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_pc_plus4", instr_pc_plus4, 32'h4);
    check("wrap_rst_addr", w_req_addr, 32'hFFFF_FFFC);
    check("wrap_rst_pc_plus4", w_pc4, 32'h4);
    @(negedge clk);
    rst = 1'b1;

    // Sequential fetch
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_req(32'(i * 4));
      push_instr(32'(i * 4));
    end
    issue_reqs(4);
    drain();

    // Wrap-around reset PC
    check("wrap_req0", w_addr_log[0], 32'hFFFF_FFFC);
    check("wrap_req1", w_addr_log[1], 32'h0000_0000);
    check("wrap_got", 32'(w_got), 32'd1);
    check("wrap_first_pc", w_first_pc, 32'hFFFF_FFFC);
    check("wrap_first_pc4", w_first_pc4, 32'h0);
    check("wrap_first_instr", w_first_instr, 32'h0000_0003);

    // Core stalled: credit stops at two
    @(negedge clk);
    instr_ready = 1'b0;
    push_req(32'h10);
    push_req(32'h14);
    issue_reqs(2);
    imem_req_ready = 1'b1;
    wait_cycles(6);
    #2;
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_instr_pc", instr_pc, 32'h10);
    check("stall_instr", instr, ~32'h10);
    imem_req_ready = 1'b0;
    push_instr(32'h10);
    push_instr(32'h14);
    instr_ready = 1'b1;
    drain();

    // Redirect with two outstanding
    @(negedge clk);
    mem_hold = 1'b1;
    push_req(32'h18);
    push_req(32'h1C);
    issue_reqs(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("flush_req_valid", 32'(imem_req_valid), 32'd0);
    mem_hold = 1'b0;
    push_req(32'h100);
    push_req(32'h104);
    push_instr(32'h100);
    push_instr(32'h104);
    issue_reqs(2);
    drain();

    // Full FIFO flushed, misaligned target, redirect on accept
    @(negedge clk);
    instr_ready = 1'b0;
    push_req(32'h108);
    push_req(32'h10C);
    issue_reqs(2);
    wait_cycles(4);
    #2;
    check("full_valid", 32'(instr_valid), 32'd1);
    check("full_pc", instr_pc, 32'h108);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    check("flush_instr_valid", 32'(instr_valid), 32'd0);
    check("align_addr", imem_req_addr, 32'h200);
    check("no_stale_req_valid", 32'(imem_req_valid), 32'd1);
    @(negedge clk);
    push_req(32'h200);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    imem_req_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    #2;
    check("flush_after_accept", 32'(imem_req_valid), 32'd0);
    push_req(32'h300);
    push_instr(32'h300);
    instr_ready = 1'b1;
    issue_reqs(1);
    drain();

    // Address wrap via redirect
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    push_req(32'hFFFF_FFFC);
    push_req(32'h0);
    push_instr(32'hFFFF_FFFC);
    push_instr(32'h0);
    issue_reqs(2);
    drain();

    // Reset mid-operation, stray response after release
    @(negedge clk);
    instr_ready = 1'b0;
    mem_hold = 1'b1;
    push_req(32'h4);
    push_req(32'h8);
    issue_reqs(2);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("mid_rst_req_addr", imem_req_addr, 32'h0);
    check("mid_rst_instr_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_instr", instr, 32'h0);
    check("mid_rst_instr_pc", instr_pc, 32'h0);
    check("mid_rst_pc_plus4", instr_pc_plus4, 32'h4);
    mem_hold = 1'b0;
    wait_cycles(2);
    rst = 1'b1;
    stray = 1'b1;
    @(negedge clk);
    #2;
    check("restart_req_valid", 32'(imem_req_valid), 32'd1);
    check("restart_req_addr", imem_req_addr, 32'h0);
    push_req(32'h0);
    push_req(32'h4);
    push_instr(32'h0);
    push_instr(32'h4);
    instr_ready = 1'b1;
    issue_reqs(2);
    drain();

    wait_cycles(2);
    check("exp_req_left", 32'(exp_req.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
